traffic_light_seq: RTL

- Sequencer that generates the data byte for the XM-23 traffic light device and holds that device's control/status byte (CSR).
- Runs a two-axis (NS/EW) light cycle: green, yellow, all-red.
- Time base: prescaled clock tick, with a latched pedestrian request that inserts a walk interval.
- Outputs feed the traffic light device CSR/DR inputs. Software configures the block through byte writes from the CPU bus.

---
 rtl/traffic_light_seq_if.sv | 31 +++
 rtl/traffic_light_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/traffic_light_seq_if.sv
// traffic_light_seq_if
//   Bus bundle between the CPU-side CSR port and the traffic light sequencer.
//   csr_wr    : one-cycle CSR write strobe
//   csr_wdata : CSR write data byte
//   csr_out   : CSR byte (pending, phase flag, enable, irq enable)
//   dr_out    : lamp data byte to the traffic light device
//   irq       : phase-flag interrupt request
//   master = CPU / driver side, slave = sequencer side.
interface traffic_light_seq_if;
  logic       csr_wr;
  logic [7:0] csr_wdata;
  logic [7:0] csr_out;
  logic [7:0] dr_out;
  logic       irq;

  modport master (
    output csr_wr,
    output csr_wdata,
    input  csr_out,
    input  dr_out,
    input  irq
  );

  modport slave (
    input  csr_wr,
    input  csr_wdata,
    output csr_out,
    output dr_out,
    output irq
  );
endinterface

// File: rtl/traffic_light_seq.sv
// traffic_light_seq
//   Generates the lamp byte for the XM-23 traffic light device and holds its
//   CSR. Cycles NS green -> NS yellow -> all-red -> EW green -> EW yellow ->
//   all-red on a prescaled tick, with a latched pedestrian request that adds a
//   walk interval at the start of the next NS green.
// Ports:
//   clk     : system clock
//   rst_n   : synchronous active-low reset
//   ped_req : pedestrian button level, sampled every clock
//   bus     : slave side of traffic_light_seq_if (csr_wr, csr_wdata in;
//             csr_out, dr_out, irq out)
module traffic_light_seq #(
  parameter int CLK_DIV  = 50000000,
  parameter int GREEN_T  = 8,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 1,
  parameter int WALK_T   = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ped_req,
  traffic_light_seq_if.slave   bus
);

  // A zero phase length would never expire, so it is promoted to one tick.
  localparam int G_EFF = (GREEN_T  == 0) ? 1 : GREEN_T;
  localparam int Y_EFF = (YELLOW_T == 0) ? 1 : YELLOW_T;
  localparam int A_EFF = (ALLRED_T == 0) ? 1 : ALLRED_T;
  localparam int W_EFF = (WALK_T > G_EFF) ? G_EFF : WALK_T;

  localparam logic [7:0] G_DUR = 8'(G_EFF);
  localparam logic [7:0] Y_DUR = 8'(Y_EFF);
  localparam logic [7:0] A_DUR = 8'(A_EFF);

  // The green timer counts down from G_DUR; walk is shown while the timer is
  // still above this value, i.e. during the first W_EFF ticks.
  localparam logic [7:0] WALK_LIM = 8'(G_EFF - W_EFF);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    AR_START,
    NS_GREEN,
    NS_YELLOW,
    AR_1,
    EW_GREEN,
    EW_YELLOW,
    AR_2
  } state_t;

  state_t        state, state_nx;
  logic [PW-1:0] presc, presc_nx;
  logic [7:0]    timer, timer_nx;
  logic          pending, pending_nx;
  logic          walk_active, walk_nx;
  logic          flag, flag_nx;
  logic          en, en_nx;
  logic          irq_en, irq_en_nx;
  logic [7:0]    dr_q, dr_nx;
  logic          irq_q, irq_nx;
  logic          tick;
  logic          enter;
  logic          ns_entry;
  logic          green_entry;

  // Next-state, timer, CSR and lamp logic. Outputs are derived from the next
  // values so the registered dr_out/irq line up with the state register.
  always_comb begin
    state_nx    = state;
    presc_nx    = presc;
    timer_nx    = timer;
    enter       = 1'b0;
    tick        = (state != IDLE) && (presc == PMAX);

    if (!en) begin
      state_nx = IDLE;
      presc_nx = '0;
      timer_nx = 8'd0;
    end else if (state == IDLE) begin
      state_nx = AR_START;
      enter    = 1'b1;
    end else if (tick) begin
      if (timer <= 8'd1) begin
        enter = 1'b1;
        case (state)
          AR_START:  state_nx = NS_GREEN;
          NS_GREEN:  state_nx = NS_YELLOW;
          NS_YELLOW: state_nx = AR_1;
          AR_1:      state_nx = EW_GREEN;
          EW_GREEN:  state_nx = EW_YELLOW;
          EW_YELLOW: state_nx = AR_2;
          AR_2:      state_nx = NS_GREEN;
          default:   state_nx = IDLE;
        endcase
      end else begin
        timer_nx = timer - 8'd1;
        presc_nx = '0;
      end
    end else begin
      presc_nx = presc + PW'(1);
    end

    // Every phase entry restarts the prescaler and loads that phase's length.
    if (enter) begin
      presc_nx = '0;
      case (state_nx)
        NS_GREEN, EW_GREEN:   timer_nx = G_DUR;
        NS_YELLOW, EW_YELLOW: timer_nx = Y_DUR;
        default:              timer_nx = A_DUR;
      endcase
    end

    ns_entry    = enter && (state_nx == NS_GREEN);
    green_entry = enter && ((state_nx == NS_GREEN) || (state_nx == EW_GREEN));

    // A request arriving in the consume cycle must survive for the next NS
    // cycle, so the set is applied after the clear.
    pending_nx = pending;
    if (ns_entry) pending_nx = 1'b0;
    if (ped_req && (state != IDLE)) pending_nx = 1'b1;

    if (state_nx != NS_GREEN) walk_nx = 1'b0;
    else if (ns_entry)        walk_nx = pending;
    else                      walk_nx = walk_active;

    en_nx     = bus.csr_wr ? bus.csr_wdata[4] : en;
    irq_en_nx = bus.csr_wr ? bus.csr_wdata[5] : irq_en;

    // W1C first, then the green-entry set so that a collision keeps the flag.
    flag_nx = flag;
    if (bus.csr_wr && bus.csr_wdata[1]) flag_nx = 1'b0;
    if (green_entry) flag_nx = 1'b1;

    irq_nx = flag_nx & irq_en_nx;

    case (state_nx)
      IDLE:      dr_nx = 8'h00;
      NS_GREEN:  dr_nx = (walk_nx && (timer_nx > WALK_LIM)) ? 8'h61 : 8'h21;
      NS_YELLOW: dr_nx = 8'h22;
      EW_GREEN:  dr_nx = 8'h0C;
      EW_YELLOW: dr_nx = 8'h14;
      default:   dr_nx = 8'h24;
    endcase
  end

  // State and output registers; reset abandons any cycle in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      presc       <= '0;
      timer       <= 8'd0;
      pending     <= 1'b0;
      walk_active <= 1'b0;
      flag        <= 1'b0;
      en          <= 1'b0;
      irq_en      <= 1'b0;
      dr_q        <= 8'h00;
      irq_q       <= 1'b0;
    end else begin
      state       <= state_nx;
      presc       <= presc_nx;
      timer       <= timer_nx;
      pending     <= pending_nx;
      walk_active <= walk_nx;
      flag        <= flag_nx;
      en          <= en_nx;
      irq_en      <= irq_en_nx;
      dr_q        <= dr_nx;
      irq_q       <= irq_nx;
    end
  end

  assign bus.csr_out = {2'b00, irq_en, en, 2'b00, flag, pending};
  assign bus.dr_out  = dr_q;
  assign bus.irq     = irq_q;

endmodule
